// File: rtl/fp_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_subtractor_seq
// Purpose  : Multi-cycle IEEE-754 single-precision subtractor (a - b) with a
//            valid/ready handshake, bit-serial alignment and normalisation,
//            truncation rounding and flush-to-zero of denormals.
//            Define FPSUB_FLAGS_EN to add the {overflow, underflow, zero}
//            flags output.
// Revision : 1.0  initial release
// ============================================================================
module fp_subtractor_seq #(
    parameter int unsigned MAX_SHIFT = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
`ifdef FPSUB_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    localparam int unsigned c_SHIFT_W = $clog2(MAX_SHIFT + 1);
    localparam logic [31:0] c_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  c_EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ALIGN   = 3'd1,
        ST_COMBINE = 3'd2,
        ST_NORM    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Working registers
    logic                 r_sign;
    logic                 r_eff_sub;
    logic [7:0]           r_exp;
    logic [23:0]          r_mant_x;
    logic [23:0]          r_mant_y;
    logic [24:0]          r_mant;
    logic [c_SHIFT_W-1:0] r_shift;
    logic [31:0]          r_result;

    // Operand decode (IDLE)
    logic [7:0]           w_a_exp;
    logic [7:0]           w_b_exp;
    logic [23:0]          w_a_mant;
    logic [23:0]          w_b_mant;
    logic                 w_b_sign;
    logic                 w_a_ge;
    logic                 w_special;
    logic                 w_accept;
    logic                 w_x_sign;
    logic                 w_y_sign;
    logic [7:0]           w_x_exp;
    logic [7:0]           w_y_exp;
    logic [23:0]          w_x_mant;
    logic [23:0]          w_y_mant;
    logic [7:0]           w_exp_diff;
    logic [c_SHIFT_W-1:0] w_shift_init;

    // Normalisation decode (NORM)
    logic                 w_norm_zero;
    logic                 w_norm_right;
    logic                 w_norm_left;
    logic                 w_norm_ovf;
    logic                 w_norm_unf;
    logic                 w_norm_pack;

    logic                 w_result_load;
    logic [31:0]          w_result_next;

    assign w_accept  = in_valid && (r_state == ST_IDLE);

    // Subtrahend enters with its sign inverted, turning a - b into a + (-b)
    assign w_a_exp   = a[30:23];
    assign w_b_exp   = b[30:23];
    assign w_a_mant  = (w_a_exp == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    assign w_b_mant  = (w_b_exp == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    assign w_b_sign  = ~b[31];
    assign w_special = (w_a_exp == c_EXP_MAX) || (w_b_exp == c_EXP_MAX);
    assign w_a_ge    = {w_a_exp, w_a_mant} >= {w_b_exp, w_b_mant};

    assign w_x_sign  = w_a_ge ? a[31]    : w_b_sign;
    assign w_y_sign  = w_a_ge ? w_b_sign : a[31];
    assign w_x_exp   = w_a_ge ? w_a_exp  : w_b_exp;
    assign w_y_exp   = w_a_ge ? w_b_exp  : w_a_exp;
    assign w_x_mant  = w_a_ge ? w_a_mant : w_b_mant;
    assign w_y_mant  = w_a_ge ? w_b_mant : w_a_mant;

    assign w_exp_diff = w_x_exp - w_y_exp;

    // A zero Y needs no alignment; beyond MAX_SHIFT the Y mantissa is all shifted out anyway
    always_comb begin
        w_shift_init = '0;
        if (w_y_mant != 24'd0) begin
            if (32'(w_exp_diff) > MAX_SHIFT) begin
                w_shift_init = c_SHIFT_W'(MAX_SHIFT);
            end else begin
                w_shift_init = c_SHIFT_W'(w_exp_diff);
            end
        end
    end

    assign w_norm_zero  = (r_mant == 25'd0);
    assign w_norm_right = r_mant[24];
    assign w_norm_left  = !r_mant[24] && !r_mant[23] && !w_norm_zero;
    assign w_norm_ovf   = w_norm_right && (r_exp == 8'd254);
    assign w_norm_unf   = w_norm_left && (r_exp == 8'd1);
    assign w_norm_pack  = !w_norm_zero && !w_norm_right && !w_norm_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_special) begin
                        w_state_next = ST_DONE;
                    end else if (w_shift_init != '0) begin
                        w_state_next = ST_ALIGN;
                    end else begin
                        w_state_next = ST_COMBINE;
                    end
                end
            end
            ST_ALIGN: begin
                if (r_shift == c_SHIFT_W'(1)) begin
                    w_state_next = ST_COMBINE;
                end
            end
            ST_COMBINE: begin
                w_state_next = ST_NORM;
            end
            ST_NORM: begin
                if (w_norm_zero || w_norm_ovf || w_norm_unf || w_norm_pack) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Every terminal outcome updates the result register exactly once per operation
    always_comb begin
        w_result_load = 1'b0;
        w_result_next = r_result;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_special) begin
                    w_result_load = 1'b1;
                    w_result_next = c_QNAN;
                end
            end
            ST_NORM: begin
                if (w_norm_zero || w_norm_unf) begin
                    w_result_load = 1'b1;
                    w_result_next = 32'd0;
                end else if (w_norm_ovf) begin
                    w_result_load = 1'b1;
                    w_result_next = {r_sign, c_EXP_MAX, 23'd0};
                end else if (w_norm_pack) begin
                    w_result_load = 1'b1;
                    w_result_next = {r_sign, r_exp, r_mant[22:0]};
                end
            end
            default: begin
                w_result_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_exp     <= 8'd0;
            r_mant_x  <= 24'd0;
            r_mant_y  <= 24'd0;
            r_mant    <= 25'd0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign    <= w_x_sign;
                        r_eff_sub <= w_x_sign ^ w_y_sign;
                        r_exp     <= w_x_exp;
                        r_mant_x  <= w_x_mant;
                        r_mant_y  <= w_y_mant;
                        r_shift   <= w_shift_init;
                    end
                end
                ST_ALIGN: begin
                    r_mant_y <= r_mant_y >> 1;
                    r_shift  <= r_shift - c_SHIFT_W'(1);
                end
                ST_COMBINE: begin
                    // X has the larger magnitude, so the difference cannot go negative
                    if (r_eff_sub) begin
                        r_mant <= {1'b0, r_mant_x} - {1'b0, r_mant_y};
                    end else begin
                        r_mant <= {1'b0, r_mant_x} + {1'b0, r_mant_y};
                    end
                end
                ST_NORM: begin
                    if (w_norm_right && !w_norm_ovf) begin
                        r_mant <= r_mant >> 1;
                        r_exp  <= r_exp + 8'd1;
                    end else if (w_norm_left && !w_norm_unf) begin
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - 8'd1;
                    end
                end
                default: begin
                    r_shift <= r_shift;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 32'd0;
        end else if (w_result_load) begin
            r_result <= w_result_next;
        end
    end

`ifdef FPSUB_FLAGS_EN
    logic [2:0] r_flags;
    logic       w_flag_ovf;
    logic       w_flag_unf;
    logic       w_flag_zero;

    assign w_flag_ovf  = (r_state == ST_NORM) && w_norm_ovf;
    assign w_flag_unf  = (r_state == ST_NORM) && w_norm_unf;
    assign w_flag_zero = (w_result_next[30:0] == 31'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'd0;
        end else if (w_result_load) begin
            r_flags <= {w_flag_ovf, w_flag_unf, w_flag_zero};
        end
    end

    assign flags = r_flags;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_fp_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_subtractor_seq
// Purpose  : Self-checking bench for fp_subtractor_seq: directed vector table,
//            stall/reset sequences and randomized operands vs. a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
`ifdef FPSUB_FLAGS_EN
    logic [2:0]  flags;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_subtractor_seq #(.MAX_SHIFT(26)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef FPSUB_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;   // 0: latency not checked
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic [2:0] exp);
`ifdef FPSUB_FLAGS_EN
        chk(name, {29'd0, flags}, {29'd0, exp});
`endif
    endtask

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    // lat counts the accept edge as 1.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready timeout: got 0, want 1");
        end
        a = ia; b = ib; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL out_valid timeout: got 0 after %0d cycles, want 1", lat);
        end
        res = result;
    endtask

    task automatic finish_hs();
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    // Reference: exact integer arithmetic and leading-one search, no cycle model
    function automatic void ref_sub(input logic [31:0] fa, input logic [31:0] fb,
                                    output logic [31:0] res, output int lat,
                                    output logic [2:0] flg, output bit lat_ok);
        int     ea, eb, ex, ey, d, p, e, sh;
        longint ma, mb, mx, my, m;
        bit     sa, sb, sx, sy;
        ea = int'(fa[30:23]);
        eb = int'(fb[30:23]);
        flg = 3'b000; lat_ok = 1'b1; lat = 0;
        if (ea == 255 || eb == 255) begin
            res = 32'h7FC00000; lat = 1; return;
        end
        ma = (ea == 0) ? 0 : (longint'(fa[22:0]) + 64'h800000);
        mb = (eb == 0) ? 0 : (longint'(fb[22:0]) + 64'h800000);
        sa = fa[31];
        sb = !fb[31];
        if (ea > eb || (ea == eb && ma >= mb)) begin
            ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
        end else begin
            ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
        end
        d = (my == 0) ? 0 : ex - ey;
        if (d > 26) d = 26;
        m = (sx == sy) ? mx + (my >> d) : mx - (my >> d);
        if (m == 0) begin
            res = 32'd0; flg = 3'b001; lat = 3 + d; return;
        end
        p = 0;
        for (int i = 0; i < 25; i++) if (m[i]) p = i;
        e = ex + p - 23;
        if (e >= 255) begin
            res = {sx, 8'hFF, 23'd0}; flg = 3'b100; lat_ok = 1'b0; return;
        end
        if (e <= 0) begin
            res = 32'd0; flg = 3'b011; lat_ok = 1'b0; return;
        end
        sh = (p >= 23) ? p - 23 : 23 - p;
        m = (p >= 23) ? (m >> sh) : (m << sh);
        res = {sx, 8'(e), m[22:0]};
        lat = 3 + d + sh;
    endfunction

    initial begin
        logic [31:0] res, ra, rb, eres;
        logic [2:0]  eflg;
        int          lat, elat, ea, eb, w;
        bit          elat_ok;

        vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 4, 3'b000}; // 3 - 1
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 3, 3'b001}; // 1 - 1
        vecs[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 4, 3'b000}; // 1 - (-1)
        vecs[3]  = '{32'h3FC00000, 32'h3FA00000, 32'h3E800000, 5, 3'b000}; // 1.5 - 1.25
        vecs[4]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 0, 3'b100}; // overflow
        vecs[5]  = '{32'h7F800000, 32'hFF7FFFFF, 32'h7FC00000, 1, 3'b000}; // Inf operand
        vecs[6]  = '{32'h00000000, 32'h00000000, 32'h00000000, 3, 3'b001}; // 0 - 0
        vecs[7]  = '{32'h40000000, 32'h00000000, 32'h40000000, 3, 3'b000}; // 2 - 0
        vecs[8]  = '{32'h4F000000, 32'h3F800000, 32'h4F000000, 29, 3'b000}; // shift cap
        vecs[9]  = '{32'h00800001, 32'h00800000, 32'h00000000, 0, 3'b011}; // underflow
        vecs[10] = '{32'h00000001, 32'h3F800000, 32'hBF800000, 3, 3'b000}; // denormal flush
        vecs[11] = '{32'hC0000000, 32'h3F800000, 32'hC0400000, 4, 3'b000}; // -2 - 1

        #2;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk_flags("reset flags", 3'b000);
        #20 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d result", i), res, vecs[i].res);
            if (vecs[i].lat != 0)
                chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk_flags($sformatf("vec%0d flags", i), vecs[i].flg);
            finish_hs();
        end

        // Consumer stall: result and handshake outputs must hold
        out_ready = 1'b0;
        run_op(32'h40400000, 32'h3F800000, res, lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d result", c), result, 32'h40000000);
            chk($sformatf("stall%0d in_ready/out_valid", c), {30'd0, in_ready, out_valid}, 32'b01);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post-stall in_ready/out_valid", {30'd0, in_ready, out_valid}, 32'b10);

        // Reset while aligning (d = 23)
        a = 32'h4B000000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("busy in_ready", {31'd0, in_ready}, 32'd0);
        #3 rst = 1'b1;
        #1;
        chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset result", result, 32'd0);
        chk_flags("midreset flags", 3'b000);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_op(32'h40400000, 32'h3F800000, res, lat);
        chk("after reset result", res, 32'h40000000);
        chk("after reset latency", 32'(lat), 32'd4);
        finish_hs();

        for (int it = 0; it < 300; it++) begin
            ea = int'($urandom_range(1, 254));
            case ($urandom_range(0, 15))
                0: ea = 0;
                1: ea = 255;
                default: ;
            endcase
            case ($urandom_range(0, 3))
                0: eb = ea;
                1: eb = ea + int'($urandom_range(0, 6)) - 3;
                2: eb = int'($urandom_range(0, 254));
                default: eb = ea - int'($urandom_range(20, 30));
            endcase
            if (eb < 0) eb = 0;
            if (eb > 254) eb = 254;
            ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 3) == 0) rb[22:0] = ra[22:0];
            if ($urandom_range(0, 1) == 0) begin
                res = ra; ra = rb; rb = res;
            end
            ref_sub(ra, rb, eres, elat, eflg, elat_ok);
            w = int'($urandom_range(0, 2));
            repeat (w) begin @(posedge clk); #1; end
            run_op(ra, rb, res, lat);
            chk($sformatf("rand%0d result a=%08h b=%08h", it, ra, rb), res, eres);
            if (elat_ok)
                chk($sformatf("rand%0d latency a=%08h b=%08h", it, ra, rb), 32'(lat), 32'(elat));
            chk_flags($sformatf("rand%0d flags a=%08h b=%08h", it, ra, rb), eflg);
            finish_hs();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
